// File: rtl/core_mgmt_pkg.sv
// rtl/core_mgmt_pkg.sv - shared constants and helpers for the core-management AXI4-Lite responder
package core_mgmt_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_TOKEN    = 0;
    localparam int REG_DOORBELL = 1;

    // Replace each byte of old_word whose strobe is set with the matching byte of new_word.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/core_mgmt_regfile.sv
// rtl/core_mgmt_regfile.sv - register bank with TOKEN test-and-set and DOORBELL pulse
module core_mgmt_regfile #(
    parameter int NUM_REGS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] waddr,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wstrb,
    input  logic [$clog2(NUM_REGS)-1:0] raddr,
    output logic [31:0]                 rdata,
    input  logic                        tas,
    output logic                        token_held,
    output logic                        doorbell
);
    import core_mgmt_pkg::*;

    localparam int IW = $clog2(NUM_REGS);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic        doorbell_q;
    logic        doorbell_d;

    // Reads see the pre-update contents, so a read racing a write returns the old value.
    assign rdata      = regs_q[raddr];
    assign token_held = regs_q[REG_TOKEN][0];
    assign doorbell   = doorbell_q;

    // Next register state: test-and-set first, then the write so a TOKEN write overrides it.
    always_comb begin
        regs_d     = regs_q;
        doorbell_d = 1'b0;
        if (tas && !regs_q[REG_TOKEN][0]) begin
            regs_d[REG_TOKEN] = 32'd1;
        end
        if (we) begin
            if (waddr == IW'(REG_TOKEN)) begin
                if (wstrb[0]) begin
                    regs_d[REG_TOKEN] = {31'd0, wdata[0]};
                end
            end else begin
                regs_d[waddr] = strb_merge(regs_q[waddr], wdata, wstrb);
                if (waddr == IW'(REG_DOORBELL)) begin
                    doorbell_d = |wstrb;
                end
            end
        end
    end

    // Register bank and doorbell pulse flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: 32'd0};
            doorbell_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            doorbell_q <= doorbell_d;
        end
    end

endmodule

// File: rtl/core_mgmt_axil_responder.sv
// rtl/core_mgmt_axil_responder.sv - AXI4-Lite slave terminating a core-management port
module core_mgmt_axil_responder #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        token_held,
    output logic        doorbell
);
    import core_mgmt_pkg::*;

    localparam int IW      = $clog2(NUM_REGS);
    localparam int TAG_LSB = 2 + IW;

    // Write-side state: parked AW/W halves and the pending response.
    logic        aw_held_q, aw_held_d;
    logic [29:0] aw_addr_q, aw_addr_d;
    logic        w_held_q,  w_held_d;
    logic [31:0] w_data_q,  w_data_d;
    logic [3:0]  w_strb_q,  w_strb_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;

    // Read-side state.
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;

    logic          aw_hs, w_hs, ar_hs, commit;
    logic [29:0]   wr_word;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic          wr_hit, rd_hit;
    logic          rf_we, rf_tas;
    logic [IW-1:0] rf_waddr, rf_raddr;
    logic [31:0]   rf_rdata;
    logic          unused_addr_bits;

    // Byte-offset bits carry no meaning for a word-wide bank.
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    // A parked channel keeps its ready low; nothing is accepted while a response is pending.
    assign awready = !rst && !bvalid_q && !aw_held_q;
    assign wready  = !rst && !bvalid_q && !w_held_q;
    assign arready = !rst && !rvalid_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    assign wr_word = aw_held_q ? aw_addr_q : awaddr[31:2];
    assign wr_data = w_held_q  ? w_data_q  : wdata;
    assign wr_strb = w_held_q  ? w_strb_q  : wstrb;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_hit   = (wr_word[29:IW] == ADDR_BASE[31:TAG_LSB]);
    assign rd_hit   = (araddr[31:TAG_LSB] == ADDR_BASE[31:TAG_LSB]);
    assign rf_waddr = wr_word[IW-1:0];
    assign rf_raddr = araddr[TAG_LSB-1:2];
    assign rf_we    = commit && wr_hit;
    assign rf_tas   = ar_hs && rd_hit && (rf_raddr == IW'(REG_TOKEN));

    core_mgmt_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we         (rf_we),
        .waddr      (rf_waddr),
        .wdata      (wr_data),
        .wstrb      (wr_strb),
        .raddr      (rf_raddr),
        .rdata      (rf_rdata),
        .tas        (rf_tas),
        .token_held (token_held),
        .doorbell   (doorbell)
    );

    // Write channel: park a lone half, commit when both halves exist, then hold the response.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_addr_d = awaddr[31:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                w_data_d = wdata;
                w_strb_d = wstrb;
            end
        end
    end

    // Read channel: capture data and response on AR, hold them until R is accepted.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? rf_rdata : 32'd0;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Channel state flops; reset drops every pending or parked transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= 30'd0;
            w_held_q  <= 1'b0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

endmodule

// File: tb/tb_core_mgmt_axil_responder.sv
// tb/tb_core_mgmt_axil_responder.sv - randomized self-checking bench for core_mgmt_axil_responder
module tb_core_mgmt_axil_responder;

    localparam int          NUM_REGS = 8;
    localparam logic [31:0] BASE     = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, bvalid, arready, rvalid, token_held, doorbell;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] mregs [NUM_REGS];

    core_mgmt_axil_responder #(.NUM_REGS(NUM_REGS), .ADDR_BASE(BASE)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .token_held(token_held), .doorbell(doorbell)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) mregs[i] = 32'd0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] exp_resp, output logic exp_db);
        logic [31:0] off;
        int idx;
        off = addr - BASE;
        exp_db = 1'b0;
        if (off >= 32'(NUM_REGS * 4)) begin
            exp_resp = 2'b10;
            return;
        end
        exp_resp = 2'b00;
        idx = int'(off / 4);
        if (idx == 0) begin
            if (strb[0]) mregs[0] = data & 32'd1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
            if (idx == 1 && strb != 4'd0) exp_db = 1'b1;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] exp_data, output logic [1:0] exp_resp);
        logic [31:0] off;
        int idx;
        off = addr - BASE;
        if (off >= 32'(NUM_REGS * 4)) begin
            exp_data = 32'd0;
            exp_resp = 2'b10;
            return;
        end
        idx = int'(off / 4);
        exp_data = mregs[idx];
        exp_resp = 2'b00;
        if (idx == 0 && mregs[0] == 32'd0) mregs[0] = 32'd1;
    endtask

    // ---------------- bus drivers (observe only) ----------------
    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int lead,
                            output logic [1:0] resp, output bit timing_ok, output bit held_ok,
                            output logic db0, output logic db1, output logic tok);
        int  aw_start, w_start;
        bit  aw_done, w_done;
        aw_start  = (lead < 0) ? -lead : 0;
        w_start   = (lead > 0) ? lead : 0;
        aw_done   = 0;
        w_done    = 0;
        held_ok   = 1;
        for (int t = 0; t < 20 && !(aw_done && w_done); t++) begin
            @(negedge clk);
            awvalid = (t >= aw_start) && !aw_done;
            awaddr  = addr;
            wvalid  = (t >= w_start) && !w_done;
            wdata   = data;
            wstrb   = strb;
            if (aw_done && awready) held_ok = 0;
            if (w_done && wready) held_ok = 0;
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
        end
        @(negedge clk);
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        timing_ok = aw_done && w_done && bvalid;
        if (awready || wready) held_ok = 0;
        resp      = bresp;
        db0       = doorbell;
        tok       = token_held;
        bready    = 1'b1;
        @(negedge clk);
        bready    = 1'b0;
        db1       = doorbell;
        if (bvalid) timing_ok = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp, output bit ok);
        @(negedge clk);
        arvalid = 1'b1;
        araddr  = addr;
        ok      = arready;
        @(negedge clk);
        arvalid = 1'b0;
        ok      = ok && rvalid;
        data    = rdata;
        resp    = rresp;
        rready  = 1'b1;
        @(negedge clk);
        rready  = 1'b0;
        if (rvalid || !arready) ok = 0;
    endtask

    // ---------------- feature tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({awready, wready, arready, bvalid, rvalid, doorbell, token_held, bresp, rresp, rdata} !== 41'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {awready, wready, arready, bvalid, rvalid, doorbell, token_held, bresp, rresp, rdata});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_release_ready: got %b expected 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [1:0] resp, er; logic [31:0] d, ed; logic db0, db1, tok, edb; bit tok_ok, hok, rok;
        model_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, er, edb);
        do_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 0, resp, tok_ok, hok, db0, db1, tok);
        tests++;
        if (!tok_ok || resp !== 2'b00) begin
            fails++;
            $display("FAIL same_cycle_write: bresp %b timing %0d expected OKAY on next cycle", resp, tok_ok);
        end
        model_read(BASE + 32'h8, ed, er);
        do_read(BASE + 32'h8, d, resp, rok);
        tests++;
        if (!rok || d !== 32'hDEAD_BEEF || resp !== 2'b00) begin
            fails++;
            $display("FAIL same_cycle_readback: got %h/%b ok %0d expected deadbeef/00", d, resp, rok);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp, er; logic [31:0] d, ed; logic db0, db1, tok, edb; bit t_ok, hok, rok;
        model_write(BASE + 32'h10, 32'h1122_3344, 4'hF, er, edb);
        do_write(BASE + 32'h10, 32'h1122_3344, 4'hF, 0, resp, t_ok, hok, db0, db1, tok);
        model_write(BASE + 32'h10, 32'h0000_AB00, 4'b0010, er, edb);
        do_write(BASE + 32'h10, 32'h0000_AB00, 4'b0010, -2, resp, t_ok, hok, db0, db1, tok);
        tests++;
        if (!hok || !t_ok || resp !== 2'b00) begin
            fails++;
            $display("FAIL w_first_write: held_ok %0d timing %0d bresp %b expected 1 1 00", hok, t_ok, resp);
        end
        model_read(BASE + 32'h10, ed, er);
        do_read(BASE + 32'h10, d, resp, rok);
        tests++;
        if (!rok || d !== 32'h1122_AB44 || d !== ed) begin
            fails++;
            $display("FAIL w_first_readback: got %h expected 1122ab44", d);
        end
    endtask

    task automatic test_token();
        logic [1:0] resp, er; logic [31:0] d, ed; logic db0, db1, tok, edb; bit t_ok, hok, rok;
        model_read(BASE, ed, er);
        do_read(BASE, d, resp, rok);
        tests++;
        if (!rok || d !== 32'd0 || token_held !== 1'b1) begin
            fails++;
            $display("FAIL token_first_read: got %h held %b expected 0 held 1", d, token_held);
        end
        model_read(BASE, ed, er);
        do_read(BASE, d, resp, rok);
        tests++;
        if (!rok || d !== 32'd1 || token_held !== 1'b1) begin
            fails++;
            $display("FAIL token_second_read: got %h held %b expected 1 held 1", d, token_held);
        end
        model_write(BASE, 32'd0, 4'h1, er, edb);
        do_write(BASE, 32'd0, 4'h1, 1, resp, t_ok, hok, db0, db1, tok);
        tests++;
        if (!t_ok || tok !== 1'b0 || resp !== 2'b00) begin
            fails++;
            $display("FAIL token_release: held %b bresp %b expected 0 00", tok, resp);
        end
    endtask

    task automatic test_doorbell();
        logic [1:0] resp, er; logic [31:0] d, ed; logic db0, db1, tok, edb; bit t_ok, hok, rok;
        model_write(BASE + 32'h4, 32'h5, 4'hF, er, edb);
        do_write(BASE + 32'h4, 32'h5, 4'hF, 0, resp, t_ok, hok, db0, db1, tok);
        tests++;
        if (!t_ok || db0 !== 1'b1 || db1 !== 1'b0) begin
            fails++;
            $display("FAIL doorbell_pulse: got %b%b expected 10", db0, db1);
        end
        model_read(BASE + 32'h4, ed, er);
        do_read(BASE + 32'h4, d, resp, rok);
        tests++;
        if (!rok || d !== 32'h5) begin
            fails++;
            $display("FAIL doorbell_readback: got %h expected 5", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp, er; logic [31:0] d, ed; logic db0, db1, tok, edb; bit t_ok, hok, rok;
        model_write(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, er, edb);
        do_write(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF, 0, resp, t_ok, hok, db0, db1, tok);
        tests++;
        if (!t_ok || resp !== 2'b10 || db0 !== 1'b0) begin
            fails++;
            $display("FAIL miss_write: bresp %b doorbell %b expected 10 0", resp, db0);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            model_read(BASE + 32'(i * 4), ed, er);
            do_read(BASE + 32'(i * 4), d, resp, rok);
            tests++;
            if (!rok || d !== ed || resp !== er) begin
                fails++;
                $display("FAIL miss_no_change idx %0d: got %h expected %h", i, d, ed);
            end
        end
        model_read(BASE + 32'h100, ed, er);
        do_read(BASE + 32'h100, d, resp, rok);
        tests++;
        if (!rok || d !== 32'd0 || resp !== 2'b10) begin
            fails++;
            $display("FAIL miss_read: got %h/%b expected 0/10", d, resp);
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [1:0] resp, er; logic [31:0] ed, d; logic db0, db1, tok, edb; bit t_ok, hok;
        logic [31:0] addrs [2];
        logic [31:0] wvals [2];
        addrs[0] = BASE;           wvals[0] = 32'd0;
        addrs[1] = BASE + 32'hC;   wvals[1] = 32'h2222_2222;
        model_write(BASE, 32'd0, 4'h1, er, edb);
        do_write(BASE, 32'd0, 4'h1, 0, resp, t_ok, hok, db0, db1, tok);
        model_write(BASE + 32'hC, 32'h1111_1111, 4'hF, er, edb);
        do_write(BASE + 32'hC, 32'h1111_1111, 4'hF, 0, resp, t_ok, hok, db0, db1, tok);
        for (int k = 0; k < 2; k++) begin
            model_read(addrs[k], ed, er);
            model_write(addrs[k], wvals[k], 4'hF, er, edb);
            @(negedge clk);
            awvalid = 1'b1; awaddr = addrs[k]; wvalid = 1'b1; wdata = wvals[k]; wstrb = 4'hF;
            arvalid = 1'b1; araddr = addrs[k];
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            tests++;
            if (!rvalid || !bvalid || rdata !== ed || token_held !== mregs[0][0]) begin
                fails++;
                $display("FAIL same_cycle_rw %0d: rdata %h held %b expected %h held %b",
                         k, rdata, token_held, ed, mregs[0][0]);
            end
            rready = 1'b1; bready = 1'b1;
            @(negedge clk);
            rready = 1'b0; bready = 1'b0;
        end
        model_read(BASE + 32'hC, ed, er);
        do_read(BASE + 32'hC, d, resp, t_ok);
        tests++;
        if (!t_ok || d !== 32'h2222_2222) begin
            fails++;
            $display("FAIL same_cycle_rw_after: got %h expected 22222222", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, data, d, ed; logic [3:0] strb; logic [1:0] resp, er;
        logic db0, db1, tok, edb; bit t_ok, hok; int sel, lead;
        for (int i = 0; i < 60; i++) begin
            sel  = int'($urandom_range(0, 8));
            addr = (sel == 8) ? BASE + 32'h100 : BASE + 32'(sel * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                lead = int'($urandom_range(0, 4)) - 2;
                model_write(addr, data, strb, er, edb);
                do_write(addr, data, strb, lead, resp, t_ok, hok, db0, db1, tok);
                tests++;
                if (!t_ok || !hok || resp !== er || db0 !== edb || db1 !== 1'b0 || tok !== mregs[0][0]) begin
                    fails++;
                    $display("FAIL rand_write %0d addr %h: bresp %b db %b%b tok %b timing %0d held %0d expected %b %b0 %b",
                             i, addr, resp, db0, db1, tok, t_ok, hok, er, edb, mregs[0][0]);
                end
            end else begin
                model_read(addr, ed, er);
                do_read(addr, d, resp, t_ok);
                tests++;
                if (!t_ok || d !== ed || resp !== er || token_held !== mregs[0][0]) begin
                    fails++;
                    $display("FAIL rand_read %0d addr %h: got %h/%b held %b expected %h/%b held %b",
                             i, addr, d, resp, token_held, ed, er, mregs[0][0]);
                end
            end
        end
    endtask

    task automatic test_backpressure_reset();
        logic [1:0] resp, er; logic [31:0] ed, d; logic db0, db1, tok, edb; bit t_ok, hok, stable;
        model_write(BASE + 32'h14, 32'hCAFE_0123, 4'hF, er, edb);
        do_write(BASE + 32'h14, 32'hCAFE_0123, 4'hF, 0, resp, t_ok, hok, db0, db1, tok);
        model_read(BASE, ed, er);
        do_read(BASE, d, resp, t_ok);
        model_read(BASE + 32'h14, ed, er);
        @(negedge clk);
        arvalid = 1'b1; araddr = BASE + 32'h14;
        @(negedge clk);
        arvalid = 1'b0;
        // Park an AW half so the reset must discard it.
        awvalid = 1'b1; awaddr = BASE + 32'h8;
        stable = 1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) awvalid = 1'b0;
            if (!rvalid || rdata !== ed || arready) stable = 0;
        end
        tests++;
        if (!stable) begin
            fails++;
            $display("FAIL backpressure_hold: rvalid %b rdata %h arready %b expected 1 %h 0", rvalid, rdata, arready, ed);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({awready, wready, arready, bvalid, rvalid, doorbell, token_held, bresp, rresp, rdata} !== 41'd0) begin
            fails++;
            $display("FAIL reset_midflight: got %h expected 0",
                     {awready, wready, arready, bvalid, rvalid, doorbell, token_held, bresp, rresp, rdata});
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (bvalid !== 1'b0 || wready !== 1'b0) begin
            fails++;
            $display("FAIL reset_drops_aw: bvalid %b wready %b expected 0 0", bvalid, wready);
        end
        model_write(BASE + 32'h18, 32'h0BAD_F00D, 4'hF, er, edb);
        awvalid = 1'b1; awaddr = BASE + 32'h18;
        @(negedge clk);
        awvalid = 1'b0;
        tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_commit: bvalid %b bresp %b expected 1 00", bvalid, bresp);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        for (int i = 2; i < NUM_REGS; i++) begin
            model_read(BASE + 32'(i * 4), ed, er);
            do_read(BASE + 32'(i * 4), d, resp, t_ok);
            tests++;
            if (!t_ok || d !== ed) begin
                fails++;
                $display("FAIL post_reset_reg idx %0d: got %h expected %h", i, d, ed);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_token();
        test_doorbell();
        test_out_of_range();
        test_same_cycle_rw();
        test_random();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
